// File: rtl/uart_tx_serial.sv
// 8N1 UART transmitter: a small byte FIFO fed by the IO decoder's write strobe,
// drained by a start/data/stop serializer with a registered TX line.
module uart_tx_serial #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_in_wr,
    output logic       uart_tx,
    output logic       busy_tx,
    output logic       tx_idle,
    output logic [4:0] fifo_count,
    output logic       overrun
);

    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [4:0]  DEPTH     = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          wr_q;
    logic [15:0]   baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    logic wr_ev;
    logic push;
    logic pop;
    logic bit_done;

    // The strobe is a level; only its rising edge counts as a write.
    assign wr_ev    = data_in_wr & ~wr_q;
    assign push     = wr_ev && (fifo_count != DEPTH);
    assign bit_done = (baud_cnt == BAUD_LAST);
    assign pop      = (fifo_count != 5'd0) &&
                      ((state == IDLE) || ((state == STOP) && bit_done));

    assign busy_tx = (fifo_count == DEPTH);
    assign tx_idle = (fifo_count == 5'd0) && (state == IDLE);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            wr_q       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            wr_q <= data_in_wr;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            // Fullness is judged before the edge, so a same-cycle pop cannot rescue it.
            if (wr_ev && !push)
                overrun <= 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 5'd1;
                2'b01:   fifo_count <= fifo_count - 5'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            uart_tx  <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            baud_cnt <= bit_done ? 16'd0 : baud_cnt + 16'd1;
            case (state)
                IDLE: begin
                    uart_tx  <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        shift   <= mem[rd_ptr];
                        uart_tx <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        bit_idx <= '0;
                        uart_tx <= shift[0];
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        shift <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            uart_tx <= shift[1];
                        end
                    end
                end
                STOP: begin
                    // Chain straight into the next start bit when more bytes wait.
                    if (bit_done) begin
                        if (pop) begin
                            shift   <= mem[rd_ptr];
                            uart_tx <= 1'b0;
                            state   <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    uart_tx <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
